eeprom_req_arbiter: RTL
=======================

EEPROM_REQ_ARBITER -- requirements
Module: eeprom_req_arbiter

Interface
REQ-001 The block SHALL have parameter N_CH, default 4, number of requesting channels (2..8).
REQ-002 The block SHALL have parameter ADDR_W, default 16, EEPROM byte-address width.
REQ-003 The block SHALL have parameter DATA_W, default 32, transfer data width.
REQ-004 The block SHALL have parameter TMO_CYC, default 1_000_000, watchdog limit in clk cycles.
REQ-005 clk  in  1  single system clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 ch_req  in  N_CH  per-channel request strobe; a rising edge registers a request.
REQ-008 ch_wr  in  N_CH  per-channel mode, 1 = write, 0 = read; sampled with the request.
REQ-009 ch_addr  in  N_CH*ADDR_W  packed per-channel addresses, channel 0 in LSBs.
REQ-010 ch_din  in  N_CH*DATA_W  packed per-channel write data.
REQ-011 ch_done  out  N_CH  one-cycle completion pulse to the served channel.
REQ-012 ch_err  out  N_CH  one-cycle error pulse (ack error or timeout), coincident with ch_done.
REQ-013 rd_data  out  DATA_W  read data of last completed read, held until next read completes.
REQ-014 ctl_req, ctl_wr  out  1, 1  request level and mode to eeprom_controller.
REQ-015 ctl_addr, ctl_din  out  ADDR_W, DATA_W  address/data to eeprom_controller.
REQ-016 ctl_busy, ctl_ack_err  in  1, 1  i2c_master busy and ack-error status.
REQ-017 ctl_dout  in  DATA_W  eeprom_controller read data.
REQ-018 grant_idx  out  $clog2(N_CH)  index of channel being served; busy_o  out  1  FSM not IDLE.

Function
REQ-019 Each channel SHALL have a pending bit set on ch_req rising edge (1-cycle registered edge detect) and latching ch_wr/addr/din into a per-channel slot.
REQ-020 A rising edge on a channel whose pending bit is already set SHALL be ignored (no overwrite of slot).
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT_BUSY, WAIT_IDLE, RESP.
REQ-022 IDLE: if any pending, select winner round-robin starting after last served index, go ISSUE next cycle.
REQ-023 ISSUE: drive ctl_req=1 with winner's slot, go WAIT_BUSY.
REQ-024 WAIT_BUSY: hold ctl_req=1 until ctl_busy=1, then go WAIT_IDLE.
REQ-025 WAIT_IDLE: hold ctl_req=1, capture ctl_ack_err as sticky error; on ctl_busy=0 deassert ctl_req, go RESP.
REQ-026 RESP: pulse ch_done (and ch_err if error) for grant_idx, clear its pending bit, load rd_data from ctl_dout if read and no error, go IDLE.
REQ-027 A new edge on the served channel arriving in RESP SHALL re-set its pending bit after clearing (set wins).
REQ-028 ctl_addr/ctl_din/ctl_wr SHALL be stable from ISSUE through WAIT_IDLE.
REQ-029 Round-robin pointer SHALL wrap from N_CH-1 to 0; with single channel pending it is granted regardless of pointer.
REQ-030 Minimum latency request edge to ctl_req SHALL be 3 cycles (edge reg, IDLE, ISSUE).

Reset
REQ-031 On reset: FSM=IDLE, pending=0, slots=0, ctl_req=0, ctl_wr=0, ctl_addr=0, ctl_din=0, ch_done=0, ch_err=0, rd_data=0, grant_idx=0, busy_o=0, RR pointer=N_CH-1 (channel 0 first).
REQ-032 Reset mid-transaction SHALL drop ctl_req the following cycle and discard all pending requests without ch_done.

Configuration
REQ-033 With EEP_ARB_TIMEOUT_EN defined, a cycle counter SHALL run in WAIT_BUSY and WAIT_IDLE; at TMO_CYC it forces ctl_req=0, goes RESP with error set.
REQ-034 Without EEP_ARB_TIMEOUT_EN, no counter SHALL exist and WAIT states wait indefinitely.

Structure
REQ-035 Package eep_arb_pkg SHALL hold the FSM state enum and default width constants.
REQ-036 Winner selection SHALL be a sub-module rr_arbiter (request vector, pointer in; one-hot grant, index out).

Verification
REQ-037 ch1 write edge, addr 16'h0010, din 32'hA1B2C3D4; model busy 1 for 50 cycles -> ctl_req high 3 cycles after edge, ch_done[1] one pulse, ch_err[1]=0.
REQ-038 ch0..ch3 edges same cycle -> grants in order 0,1,2,3; next round after ch3 starts at 0.
REQ-039 ch2 read, ctl_dout=32'h12345678 -> rd_data=32'h12345678 in cycle after RESP.
REQ-040 ack_err pulsed during WAIT_IDLE on ch0 write -> ch_done[0] and ch_err[0] together, rd_data unchanged.
REQ-041 EEP_ARB_TIMEOUT_EN, TMO_CYC=100, busy never asserted -> ctl_req drops at cycle 100, ch_err pulses.
REQ-042 reset asserted during WAIT_IDLE with 2 pending -> ctl_req=0 next cycle, pending=0, no ch_done.

Source files
------------

// File: rtl/eep_arb_pkg.sv
// Shared definitions for the EEPROM request arbiter: FSM state encoding and default sizes.
package eep_arb_pkg;

    localparam int unsigned DEF_N_CH    = 4;
    localparam int unsigned DEF_ADDR_W  = 16;
    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_TMO_CYC = 1_000_000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_WAIT_IDLE = 3'd3,
        ST_RESP      = 3'd4
    } state_e;

endpackage

// File: rtl/eeprom_req_arbiter_rr.sv
// Round-robin winner select: first requester strictly after ptr, wrapping at N-1.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt_c,
    output logic [$clog2(N)-1:0] idx_c,
    output logic                 any_c
);

    localparam int unsigned IW = $clog2(N);

    int unsigned     cand;
    logic [IW-1:0]   cidx;

    always_comb begin
        gnt_c = '0;
        idx_c = '0;
        any_c = 1'b0;
        cand  = 0;
        cidx  = '0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = (32'(ptr) + k) % N;
            cidx = IW'(cand);
            if (!any_c && req[cidx]) begin
                any_c       = 1'b1;
                idx_c       = cidx;
                gnt_c       = '0;
                gnt_c[cidx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eeprom_req_arbiter.sv
// Multi-channel request arbiter in front of eeprom_controller.
// Optional watchdog on the controller handshake: define EEP_ARB_TIMEOUT_EN.
module eeprom_req_arbiter
    import eep_arb_pkg::*;
#(
    parameter int unsigned N_CH    = DEF_N_CH,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned TMO_CYC = DEF_TMO_CYC
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_CH-1:0]          ch_req,
    input  logic [N_CH-1:0]          ch_wr,
    input  logic [N_CH*ADDR_W-1:0]   ch_addr,
    input  logic [N_CH*DATA_W-1:0]   ch_din,
    output logic [N_CH-1:0]          ch_done,
    output logic [N_CH-1:0]          ch_err,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     ctl_req,
    output logic                     ctl_wr,
    output logic [ADDR_W-1:0]        ctl_addr,
    output logic [DATA_W-1:0]        ctl_din,
    input  logic                     ctl_busy,
    input  logic                     ctl_ack_err,
    input  logic [DATA_W-1:0]        ctl_dout,
    output logic [$clog2(N_CH)-1:0]  grant_idx,
    output logic                     busy_o
);

    localparam int unsigned IDX_W = $clog2(N_CH);

    state_e                        state_q, state_d;
    logic [N_CH-1:0]               ch_req_q, ch_req_d;
    logic [N_CH-1:0]               pend_q, pend_d;
    logic [N_CH-1:0]               slot_wr_q, slot_wr_d;
    logic [N_CH-1:0][ADDR_W-1:0]   slot_addr_q, slot_addr_d;
    logic [N_CH-1:0][DATA_W-1:0]   slot_din_q, slot_din_d;
    logic [IDX_W-1:0]              ptr_q, ptr_d;
    logic [IDX_W-1:0]              grant_q, grant_d;
    logic [N_CH-1:0]               gnt_oh_q, gnt_oh_d;
    logic                          err_q, err_d;
    logic                          ctl_req_q, ctl_req_d;
    logic                          ctl_wr_q, ctl_wr_d;
    logic [ADDR_W-1:0]             ctl_addr_q, ctl_addr_d;
    logic [DATA_W-1:0]             ctl_din_q, ctl_din_d;
    logic [N_CH-1:0]               ch_done_q, ch_done_d;
    logic [N_CH-1:0]               ch_err_q, ch_err_d;
    logic [DATA_W-1:0]             rd_data_q, rd_data_d;
    logic                          busy_q, busy_d;
    logic [N_CH-1:0]               req_rise_c;
    logic [N_CH-1:0]               win_gnt_c;
    logic [IDX_W-1:0]              win_idx_c;
    logic                          win_any_c;

`ifdef EEP_ARB_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TMO_CYC + 1);
    logic [TMO_W-1:0]              tmo_cnt_q, tmo_cnt_d;
`endif

    rr_arbiter #(.N(N_CH)) u_rr (
        .req   (pend_q),
        .ptr   (ptr_q),
        .gnt_c (win_gnt_c),
        .idx_c (win_idx_c),
        .any_c (win_any_c)
    );

    // Request capture, transaction sequencing and response generation.
    always_comb begin
        state_d     = state_q;
        ch_req_d    = ch_req;
        pend_d      = pend_q;
        slot_wr_d   = slot_wr_q;
        slot_addr_d = slot_addr_q;
        slot_din_d  = slot_din_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        gnt_oh_d    = gnt_oh_q;
        err_d       = err_q;
        ctl_req_d   = ctl_req_q;
        ctl_wr_d    = ctl_wr_q;
        ctl_addr_d  = ctl_addr_q;
        ctl_din_d   = ctl_din_q;
        ch_done_d   = '0;
        ch_err_d    = '0;
        rd_data_d   = rd_data_q;
        req_rise_c  = ch_req & ~ch_req_q;
`ifdef EEP_ARB_TIMEOUT_EN
        tmo_cnt_d   = '0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (win_any_c) begin
                    state_d    = ST_ISSUE;
                    grant_d    = win_idx_c;
                    gnt_oh_d   = win_gnt_c;
                    ptr_d      = win_idx_c;
                    ctl_wr_d   = slot_wr_q[win_idx_c];
                    ctl_addr_d = slot_addr_q[win_idx_c];
                    ctl_din_d  = slot_din_q[win_idx_c];
                end
            end
            ST_ISSUE: begin
                ctl_req_d = 1'b1;
                err_d     = 1'b0;
                state_d   = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (ctl_busy) begin
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (ctl_ack_err) begin
                    err_d = 1'b1;
                end
                if (!ctl_busy) begin
                    ctl_req_d = 1'b0;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                ch_done_d = gnt_oh_q;
                ch_err_d  = err_q ? gnt_oh_q : '0;
                pend_d    = pend_q & ~gnt_oh_q;
                if (!ctl_wr_q && !err_q) begin
                    rd_data_d = ctl_dout;
                end
                state_d = ST_IDLE;
            end
            default: begin
                state_d   = ST_IDLE;
                ctl_req_d = 1'b0;
            end
        endcase

`ifdef EEP_ARB_TIMEOUT_EN
        // Watchdog overrides the normal wait exits once the limit is reached.
        if (state_q == ST_WAIT_BUSY || state_q == ST_WAIT_IDLE) begin
            if (tmo_cnt_q == TMO_W'(TMO_CYC - 1)) begin
                ctl_req_d = 1'b0;
                err_d     = 1'b1;
                state_d   = ST_RESP;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
        end
`endif

        // Applied after the RESP clear so a new edge on the served channel wins.
        for (int i = 0; i < N_CH; i++) begin
            if (req_rise_c[i] && !pend_d[i]) begin
                pend_d[i]      = 1'b1;
                slot_wr_d[i]   = ch_wr[i];
                slot_addr_d[i] = ch_addr[i*ADDR_W +: ADDR_W];
                slot_din_d[i]  = ch_din[i*DATA_W +: DATA_W];
            end
        end

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            ch_req_q    <= '0;
            pend_q      <= '0;
            slot_wr_q   <= '0;
            slot_addr_q <= '0;
            slot_din_q  <= '0;
            ptr_q       <= IDX_W'(N_CH - 1);
            grant_q     <= '0;
            gnt_oh_q    <= '0;
            err_q       <= 1'b0;
            ctl_req_q   <= 1'b0;
            ctl_wr_q    <= 1'b0;
            ctl_addr_q  <= '0;
            ctl_din_q   <= '0;
            ch_done_q   <= '0;
            ch_err_q    <= '0;
            rd_data_q   <= '0;
            busy_q      <= 1'b0;
`ifdef EEP_ARB_TIMEOUT_EN
            tmo_cnt_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ch_req_q    <= ch_req_d;
            pend_q      <= pend_d;
            slot_wr_q   <= slot_wr_d;
            slot_addr_q <= slot_addr_d;
            slot_din_q  <= slot_din_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            gnt_oh_q    <= gnt_oh_d;
            err_q       <= err_d;
            ctl_req_q   <= ctl_req_d;
            ctl_wr_q    <= ctl_wr_d;
            ctl_addr_q  <= ctl_addr_d;
            ctl_din_q   <= ctl_din_d;
            ch_done_q   <= ch_done_d;
            ch_err_q    <= ch_err_d;
            rd_data_q   <= rd_data_d;
            busy_q      <= busy_d;
`ifdef EEP_ARB_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
`endif
        end
    end

    assign ch_done   = ch_done_q;
    assign ch_err    = ch_err_q;
    assign rd_data   = rd_data_q;
    assign ctl_req   = ctl_req_q;
    assign ctl_wr    = ctl_wr_q;
    assign ctl_addr  = ctl_addr_q;
    assign ctl_din   = ctl_din_q;
    assign grant_idx = grant_q;
    assign busy_o    = busy_q;

endmodule
